// File: rtl/vram_pos_fetch_arbiter_pkg.sv
// Shared types and defaults for the sprite-position fetch arbiter.
package vram_pos_fetch_arbiter_pkg;

  localparam int unsigned DEF_WIDTH      = 16;
  localparam int unsigned DEF_ADDR_WIDTH = 10;
  localparam int unsigned DEF_NUM_POS    = 30;
  localparam int unsigned DEF_BASE_ADDR  = 32'h100;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;

  // Index counter width; a one-entry table still needs a 1-bit counter.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vram_pos_fetch_arbiter_if.sv
// BRAM port B plus secondary requester handshake, as seen by the arbiter.
interface vram_pos_fetch_arbiter_if
  import vram_pos_fetch_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
);
  logic [ADDR_WIDTH-1:0] addr_b;
  logic                  we_b;
  logic [WIDTH-1:0]      data_b;
  logic [WIDTH-1:0]      q_b;
  logic                  req_valid;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [WIDTH-1:0]      req_wdata;
  logic                  req_ready;
  logic                  rsp_valid;
  logic [WIDTH-1:0]      rsp_data;

  modport master (
    output addr_b, we_b, data_b, req_ready, rsp_valid, rsp_data,
    input  q_b, req_valid, req_we, req_addr, req_wdata
  );

  modport slave (
    input  addr_b, we_b, data_b, req_ready, rsp_valid, rsp_data,
    output q_b, req_valid, req_we, req_addr, req_wdata
  );
endinterface

// File: rtl/vram_pos_fetch_arbiter_pos_regfile.sv
// Position register bank written by index; optional shadow bank (POS_DOUBLE_BUFFER_EN)
// copied to the visible bank on the commit strobe.
module vram_pos_fetch_arbiter_pos_regfile
  import vram_pos_fetch_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned NUM_POS = DEF_NUM_POS,
  parameter int unsigned CNT_W   = cnt_width(NUM_POS)
) (
  input  logic                     clk50MHz,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [CNT_W-1:0]         wr_idx,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     commit,
  output logic [NUM_POS*WIDTH-1:0] pos_flat
);

`ifdef POS_DOUBLE_BUFFER_EN
  logic [NUM_POS*WIDTH-1:0] shadow_q;

  // Capture lands in the shadow; bitGen only sees whole frames.
  always_ff @(posedge clk50MHz or negedge clr) begin
    if (!clr) begin
      shadow_q <= '0;
      pos_flat <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_POS; i++) begin
        if (wr_en && (wr_idx == CNT_W'(i))) shadow_q[i*WIDTH +: WIDTH] <= wr_data;
      end
      if (commit) pos_flat <= shadow_q;
    end
  end
`else
  logic unused_commit;
  assign unused_commit = commit;

  always_ff @(posedge clk50MHz or negedge clr) begin
    if (!clr) begin
      pos_flat <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_POS; i++) begin
        if (wr_en && (wr_idx == CNT_W'(i))) pos_flat[i*WIDTH +: WIDTH] <= wr_data;
      end
    end
  end
`endif

endmodule

// File: rtl/vram_pos_fetch_arbiter.sv
// Owns BRAM port B: per-frame burst read of sprite positions, secondary access in between.
// Optional feature macro: POS_DOUBLE_BUFFER_EN (shadow bank, atomic commit).
module vram_pos_fetch_arbiter
  import vram_pos_fetch_arbiter_pkg::*;
#(
  parameter int unsigned           WIDTH      = DEF_WIDTH,
  parameter int unsigned           ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned           NUM_POS    = DEF_NUM_POS,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(DEF_BASE_ADDR)
) (
  input  logic                     clk50MHz,
  input  logic                     clr,
  input  logic                     frame_strb,
  vram_pos_fetch_arbiter_if.master bus,
  output logic [NUM_POS*WIDTH-1:0] pos_flat,
  output logic                     busy,
  output logic                     overrun
);

  localparam int unsigned      CNT_W = cnt_width(NUM_POS);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(NUM_POS - 1);

  state_t           state_q, state_n;
  logic [CNT_W-1:0] issue_q, issue_n;
  logic [CNT_W-1:0] cap_idx_q, cap_idx_n;
  logic             cap_en_q, cap_en_n;
  logic             commit_c;
  logic             accept_c;
  logic             rsp_valid_q;

  // State register and fetch bookkeeping.
  always_ff @(posedge clk50MHz or negedge clr) begin
    if (!clr) begin
      state_q     <= ST_IDLE;
      issue_q     <= '0;
      cap_idx_q   <= '0;
      cap_en_q    <= 1'b0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_n;
      issue_q     <= issue_n;
      cap_idx_q   <= cap_idx_n;
      cap_en_q    <= cap_en_n;
      busy        <= (state_n != ST_IDLE);
      overrun     <= overrun | (frame_strb && (state_q != ST_IDLE));
      rsp_valid_q <= accept_c && !bus.req_we;
    end
  end

  // Next state; capture index trails the issued address by one cycle.
  always_comb begin
    state_n   = state_q;
    issue_n   = issue_q;
    cap_idx_n = cap_idx_q;
    cap_en_n  = 1'b0;
    commit_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (frame_strb) begin
          state_n = ST_FETCH;
          issue_n = '0;
        end
      end
      ST_FETCH: begin
        cap_en_n  = 1'b1;
        cap_idx_n = issue_q;
        if (issue_q == LAST) state_n = ST_DRAIN;
        else                 issue_n = issue_q + CNT_W'(1);
      end
      ST_DRAIN:  state_n = ST_COMMIT;
      ST_COMMIT: begin
        commit_c = 1'b1;
        state_n  = ST_IDLE;
      end
      default:   state_n = ST_IDLE;
    endcase
  end

  // Port B mux: the secondary path is combinational so a read returns q_b one cycle later.
  assign accept_c      = (state_q == ST_IDLE) && !frame_strb && bus.req_valid;
  assign bus.req_ready = accept_c;
  assign bus.addr_b    = (state_q == ST_FETCH) ? (BASE_ADDR + ADDR_WIDTH'(issue_q))
                       : accept_c              ? bus.req_addr
                       :                         '0;
  assign bus.we_b      = accept_c && bus.req_we;
  assign bus.data_b    = (accept_c && bus.req_we) ? bus.req_wdata : '0;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_valid_q ? bus.q_b : '0;

  vram_pos_fetch_arbiter_pos_regfile #(
    .WIDTH   (WIDTH),
    .NUM_POS (NUM_POS),
    .CNT_W   (CNT_W)
  ) u_pos_regfile (
    .clk50MHz (clk50MHz),
    .clr      (clr),
    .wr_en    (cap_en_q),
    .wr_idx   (cap_idx_q),
    .wr_data  (bus.q_b),
    .commit   (commit_c),
    .pos_flat (pos_flat)
  );

endmodule

// File: tb/tb_vram_pos_fetch_arbiter.sv
// Directed self-checking bench for vram_pos_fetch_arbiter with a behavioural BRAM on port B.
module tb_vram_pos_fetch_arbiter;

  localparam int NUM = 30;
  localparam int W   = 16;

  logic              clk50MHz;
  logic              clr;
  logic              frame_strb;
  logic [NUM*W-1:0]  pos_flat;
  logic              busy;
  logic              overrun;
  logic [15:0]       mem [1024];

  int checks;
  int errors;

  vram_pos_fetch_arbiter_if #(.WIDTH(16), .ADDR_WIDTH(10)) bus ();

  vram_pos_fetch_arbiter dut (
    .clk50MHz   (clk50MHz),
    .clr        (clr),
    .frame_strb (frame_strb),
    .bus        (bus),
    .pos_flat   (pos_flat),
    .busy       (busy),
    .overrun    (overrun)
  );

  initial clk50MHz = 1'b0;
  always #10 clk50MHz = ~clk50MHz;

  // Read-first BRAM, 1-cycle read latency.
  always @(posedge clk50MHz) begin
    if (bus.we_b) mem[bus.addr_b] <= bus.data_b;
    bus.q_b <= mem[bus.addr_b];
  end

  task automatic tick();
    @(posedge clk50MHz);
    #1;
  endtask

  function automatic logic [15:0] word(input int i);
    return pos_flat[i*W +: W];
  endfunction

  task automatic load_mem(input int mul, input int add);
    for (int i = 0; i < NUM; i++) begin
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_addr  = 10'(256 + i);
      bus.req_wdata = 16'(i * mul + add);
      tick();
    end
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
  endtask

  task automatic test_reset();
    clr = 1'b0; frame_strb = 1'b0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    repeat (3) tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    checks++; if (pos_flat !== '0) begin errors++; $display("FAIL reset_pos: got %h want 0", pos_flat); end
    checks++; if ({bus.addr_b, bus.we_b, bus.data_b, bus.req_ready, bus.rsp_valid, bus.rsp_data} !== '0) begin
      errors++; $display("FAIL reset_bus: addr %h we %b data %h rdy %b rv %b rd %h want all 0",
                         bus.addr_b, bus.we_b, bus.data_b, bus.req_ready, bus.rsp_valid, bus.rsp_data);
    end
    clr = 1'b1;
    tick();
  endtask

  task automatic test_secondary();
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 10'h005; bus.req_wdata = 16'hBEEF;
    #1;
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL wr_ready: got %b want 1", bus.req_ready); end
    checks++; if ({bus.we_b, bus.addr_b, bus.data_b} !== {1'b1, 10'h005, 16'hBEEF}) begin
      errors++; $display("FAIL wr_port: we %b addr %h data %h want 1 005 beef", bus.we_b, bus.addr_b, bus.data_b);
    end
    tick();
    bus.req_valid = 1'b0; bus.req_we = 1'b0;
    #1;
    checks++; if ({bus.we_b, bus.rsp_valid} !== 2'b00) begin
      errors++; $display("FAIL wr_one_cycle: we %b rsp_valid %b want 0 0", bus.we_b, bus.rsp_valid);
    end
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 10'h005;
    #1;
    checks++; if ({bus.req_ready, bus.we_b} !== 2'b10) begin
      errors++; $display("FAIL rd_accept: ready %b we %b want 1 0", bus.req_ready, bus.we_b);
    end
    tick();
    bus.req_valid = 1'b0;
    #1;
    checks++; if ({bus.rsp_valid, bus.rsp_data} !== {1'b1, 16'hBEEF}) begin
      errors++; $display("FAIL rd_rsp: valid %b data %h want 1 beef", bus.rsp_valid, bus.rsp_data);
    end
    tick();
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rd_rsp_pulse: got %b want 0", bus.rsp_valid); end
  endtask

  task automatic test_fetch();
    int cnt;
    int addr_bad;
    load_mem(3, 0);
    frame_strb = 1'b1;
    tick();
    frame_strb = 1'b0;
    cnt = 0; addr_bad = 0;
    while (busy && cnt < 40) begin
      if (cnt < NUM && bus.addr_b !== 10'(256 + cnt)) addr_bad++;
      if (cnt < NUM && bus.we_b !== 1'b0) addr_bad++;
      cnt++;
      tick();
    end
    checks++; if (cnt !== 32) begin errors++; $display("FAIL fetch_busy_len: got %0d want 32", cnt); end
    checks++; if (addr_bad !== 0) begin errors++; $display("FAIL fetch_addr_seq: got %0d bad cycles want 0", addr_bad); end
    for (int i = 0; i < NUM; i++) begin
      checks++; if (word(i) !== 16'(i * 3)) begin
        errors++; $display("FAIL fetch_pos[%0d]: got %h want %h", i, word(i), 16'(i * 3));
      end
    end
  endtask

  task automatic test_tie();
    int k;
    frame_strb = 1'b1;
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 10'h005;
    #1;
    checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL tie_ready: got %b want 0", bus.req_ready); end
    tick();
    frame_strb = 1'b0;
    k = 0;
    while (!bus.req_ready && k < 40) begin
      tick();
      k++;
    end
    checks++; if (k !== 32) begin errors++; $display("FAIL tie_served_at: got %0d want 32", k); end
    tick();
    bus.req_valid = 1'b0;
    #1;
    checks++; if ({bus.rsp_valid, bus.rsp_data} !== {1'b1, 16'hBEEF}) begin
      errors++; $display("FAIL tie_rsp: valid %b data %h want 1 beef", bus.rsp_valid, bus.rsp_data);
    end
    tick();
  endtask

  task automatic test_overrun();
    int idx;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_pre: got %b want 0", overrun); end
    frame_strb = 1'b1;
    tick();
    frame_strb = 1'b0;
    repeat (10) tick();
    frame_strb = 1'b1;
    tick();
    frame_strb = 1'b0;
    idx = 11;
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b want 1", overrun); end
    while (busy && idx < 60) begin
      tick();
      idx++;
    end
    checks++; if (idx !== 32) begin errors++; $display("FAIL ovr_no_restart: got %0d want 32", idx); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
    checks++; if (word(29) !== 16'd87) begin errors++; $display("FAIL ovr_pos29: got %h want 0057", word(29)); end
  endtask

  task automatic test_clr();
    int cnt;
    frame_strb = 1'b1;
    tick();
    frame_strb = 1'b0;
    repeat (15) tick();
    clr = 1'b0;
    #1;
    checks++; if ({busy, overrun, bus.rsp_valid, bus.we_b} !== 4'b0000) begin
      errors++; $display("FAIL clr_flags: busy %b ovr %b rv %b we %b want 0", busy, overrun, bus.rsp_valid, bus.we_b);
    end
    checks++; if (bus.addr_b !== '0) begin errors++; $display("FAIL clr_addr: got %h want 0", bus.addr_b); end
    checks++; if (pos_flat !== '0) begin errors++; $display("FAIL clr_pos: got %h want 0", pos_flat); end
    tick();
    clr = 1'b1;
    tick();
    load_mem(5, 1);
    frame_strb = 1'b1;
    tick();
    frame_strb = 1'b0;
    cnt = 0;
    while (busy && cnt < 40) begin
      tick();
      cnt++;
    end
    checks++; if (cnt !== 32) begin errors++; $display("FAIL clr_refetch_len: got %0d want 32", cnt); end
    for (int i = 0; i < NUM; i++) begin
      checks++; if (word(i) !== 16'(i * 5 + 1)) begin
        errors++; $display("FAIL clr_refetch[%0d]: got %h want %h", i, word(i), 16'(i * 5 + 1));
      end
    end
  endtask

  task automatic test_commit();
    load_mem(7, 2);
    frame_strb = 1'b1;
    tick();
    frame_strb = 1'b0;
    repeat (2) tick();
`ifdef POS_DOUBLE_BUFFER_EN
    checks++; if ({word(0), word(1)} !== {16'd1, 16'd6}) begin
      errors++; $display("FAIL commit_early: got %h %h want 0001 0006", word(0), word(1));
    end
`else
    checks++; if ({word(0), word(1)} !== {16'd2, 16'd6}) begin
      errors++; $display("FAIL direct_early: got %h %h want 0002 0006", word(0), word(1));
    end
`endif
    repeat (29) tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL commit_busy: got %b want 1", busy); end
`ifdef POS_DOUBLE_BUFFER_EN
    checks++; if ({word(0), word(29)} !== {16'd1, 16'd146}) begin
      errors++; $display("FAIL commit_old: got %h %h want 0001 0092", word(0), word(29));
    end
`else
    checks++; if ({word(28), word(29)} !== {16'd198, 16'd205}) begin
      errors++; $display("FAIL direct_late: got %h %h want 00c6 00cd", word(28), word(29));
    end
`endif
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL commit_done: got %b want 0", busy); end
    for (int i = 0; i < NUM; i++) begin
      checks++; if (word(i) !== 16'(i * 7 + 2)) begin
        errors++; $display("FAIL commit_new[%0d]: got %h want %h", i, word(i), 16'(i * 7 + 2));
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_secondary();
    test_fetch();
    test_tie();
    test_overrun();
    test_clr();
    test_commit();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
